// File: rtl/approx_add_pkg.sv
// approx_add_pkg: shared state type and constants for the speculative-carry adder
// Contents: state_t (IDLE, CALC, FIX, OUT), MODE_APPROX/MODE_EXACT, ERRCNT_W
package approx_add_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;
    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;
    localparam int   ERRCNT_W    = 16;
endpackage

// File: rtl/approx_add_seg.sv
// approx_add_seg: combinational SEG-bit segment adder with carry in/out
// Ports: a, b (SEG) operands; cin carry in; sum (SEG) result; cout carry out
module approx_add_seg
    import approx_add_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);
    always_comb {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
endmodule

// File: rtl/approx_adder_seq.sv
// approx_adder_seq: handshaked split-carry approximate adder with optional exact correction
// Ports: clk, rst (sync, active-high); in_valid/in_ready, mode (0 approx, 1 exact), a, b;
//        out_valid/out_ready, sum, cout, err (a segment carry speculation missed).
// Optional: define APPROX_ADDER_ERRCNT_EN to add err_cnt_clr input and err_cnt (16) output.
module approx_adder_seq
    import approx_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef APPROX_ADDER_ERRCNT_EN
    input  logic                err_cnt_clr,
    output logic [ERRCNT_W-1:0] err_cnt,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    sum,
    output logic                cout,
    output logic                err
);
    localparam int NSEG = WIDTH / SEG;
    localparam int KW   = $clog2(NSEG);

    if (NSEG < 2 || WIDTH % SEG != 0) begin : g_bad_cfg
        $error("approx_adder_seq: WIDTH must be a multiple of SEG with at least two segments");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              mode_q, mode_d;
    logic [NSEG-1:0]   carry_q, carry_d, miss_q, miss_d;
    logic [KW-1:0]     k_q, k_d;

    logic [NSEG-1:0]   spec_cin, c_carry, miss;
    logic [WIDTH-1:0]  c_sum;
    logic [SEG-1:0]    f_sum;
    logic              f_cout;

    // Speculative pass: each segment guesses its carry-in from the top bits of the segment below.
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        if (i == 0) begin : g_lsb
            assign spec_cin[i] = 1'b0;
            assign miss[i]     = 1'b0;
        end else begin : g_hi
            assign spec_cin[i] = a_q[i*SEG-1] & b_q[i*SEG-1];
            assign miss[i]     = spec_cin[i] ^ c_carry[i-1];
        end
        approx_add_seg #(.SEG(SEG)) u_seg (
            .a    (a_q[i*SEG +: SEG]),
            .b    (b_q[i*SEG +: SEG]),
            .cin  (spec_cin[i]),
            .sum  (c_sum[i*SEG +: SEG]),
            .cout (c_carry[i])
        );
    end

    // Correction pass: one shared segment adder walks k upward using the already-corrected carry below.
    approx_add_seg #(.SEG(SEG)) u_fix (
        .a    (a_q[k_q*SEG +: SEG]),
        .b    (b_q[k_q*SEG +: SEG]),
        .cin  (carry_q[k_q - 1'b1]),
        .sum  (f_sum),
        .cout (f_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        miss_d  = miss_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                mode_d  = mode;
                state_d = CALC;
            end
            CALC: begin
                sum_d   = c_sum;
                carry_d = c_carry;
                miss_d  = miss;
                k_d     = KW'(1);
                state_d = (mode_q == MODE_EXACT && |miss) ? FIX : OUT;
            end
            FIX: begin
                sum_d[k_q*SEG +: SEG] = f_sum;
                carry_d[k_q]          = f_cout;
                k_d                   = k_q + 1'b1;
                state_d               = (k_q == KW'(NSEG-1)) ? OUT : FIX;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_APPROX;
            sum_q   <= '0;
            carry_q <= '0;
            miss_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            miss_q  <= miss_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign sum       = sum_q;
    assign cout      = carry_q[NSEG-1];
    assign err       = |miss_q;

`ifdef APPROX_ADDER_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    // Clear wins over increment; increment saturates at all-ones.
    always_comb err_cnt_d = err_cnt_clr ? '0 :
                            (out_valid && out_ready && err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`endif
endmodule
